// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter family: end-of-range mode
// encodings and a range clamp used when loading values.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'd0;
  localparam logic [1:0] MODE_STOP   = 2'd1;
  localparam logic [1:0] MODE_RELOAD = 2'd2;

  function automatic logic [31:0] clamp(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Clock-enable divider: emits one step per PRESCALE enabled cycles.
// Reusable for LED blink and debounce timing.
module prescaler_tick #(
  parameter int PRESCALE = 1,
  parameter int PS_BITS  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic enable,
  output logic step
);

  localparam logic [PS_BITS-1:0] LAST = PS_BITS'(PRESCALE - 1);

  logic [PS_BITS-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == LAST);
  assign step   = enable && w_last;

  // Disabled cycles freeze the phase rather than restarting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clr)    r_cnt <= '0;
    else if (enable) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap/stop/reload end-of-range handling,
// parallel load, prescaled stepping and a registered terminal-count pulse.
module prog_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MIN_VALUE   = 0,
  parameter int MAX_VALUE   = 255,
  parameter int RESET_VALUE = 0,
  parameter int PRESCALE    = 1,
  parameter int PS_BITS     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             count_down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_count, r_reload;
  logic             r_tc;
  logic [WIDTH-1:0] w_lim, w_next, w_load_c;
  logic             w_step, w_at, w_clr;

  assign w_clr = srst | load;

  prescaler_tick #(
    .PRESCALE (PRESCALE),
    .PS_BITS  (PS_BITS)
  ) u_ps (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .enable (enable),
    .step   (w_step)
  );

  assign w_lim    = count_down ? MIN_V : MAX_V;
  assign w_at     = (r_count == w_lim);
  assign w_load_c = WIDTH'(clamp(32'(load_value), 32'(MIN_VALUE), 32'(MAX_VALUE)));

  // Reserved mode 3 falls into the default arm and holds like STOP.
  always_comb begin
    w_next = r_count;
    if (!w_at) begin
      w_next = count_down ? r_count - 1'b1 : r_count + 1'b1;
    end else begin
      case (mode)
        MODE_WRAP:   w_next = count_down ? MAX_V : MIN_V;
        MODE_RELOAD: w_next = r_reload;
        default:     w_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= RST_V;
      r_reload <= RST_V;
      r_tc     <= 1'b0;
    end else if (srst) begin
      r_count  <= RST_V;
      r_reload <= RST_V;
      r_tc     <= 1'b0;
    end else if (load) begin
      r_count  <= w_load_c;
      r_reload <= w_load_c;
      r_tc     <= 1'b0;
    end else begin
      // Only an arrival at the limit pulses tc; sitting on it does not.
      r_tc <= w_step && (w_next == w_lim) && !w_at;
      if (w_step) r_count <= w_next;
    end
  end

  assign count    = r_count;
  assign at_limit = w_at;
  assign tc       = r_tc;

endmodule
